// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory-side signals of the shared memory port.
// slave: the arbiter's view. master: the requesters' and memory model's view.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req0_strobe;
  logic          req0_rw;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req0_ready;
  logic [DW-1:0] req0_rdata;

  logic          req1_strobe;
  logic          req1_rw;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          req1_ready;
  logic [DW-1:0] req1_rdata;

  logic          mem_strobe;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [1:0]    grant;

  modport slave (
    input  req0_strobe, req0_rw, req0_addr, req0_wdata,
    input  req1_strobe, req1_rw, req1_addr, req1_wdata,
    input  mem_rdata,
    output req0_ready, req0_rdata, req1_ready, req1_rdata,
    output mem_strobe, mem_rw, mem_addr, mem_wdata, grant
  );

  modport master (
    output req0_strobe, req0_rw, req0_addr, req0_wdata,
    output req1_strobe, req1_rw, req1_addr, req1_wdata,
    output mem_rdata,
    input  req0_ready, req0_rdata, req1_ready, req1_rdata,
    input  mem_strobe, mem_rw, mem_addr, mem_wdata, grant
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single memory port: grant, WAIT_CYCLES access cycles, one ready cycle.
// Losers simply keep their strobe high; there is no other backpressure and no timeout.
module mem_port_arbiter #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic [1:0]    grant_q, grant_d;
  logic          mem_rw_q, mem_rw_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          pick1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 2'b00;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    pick1        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0_strobe || bus.req1_strobe) begin
          // On a tie the requester that was not served last wins.
          pick1        = bus.req1_strobe && (!bus.req0_strobe || !last_grant_q);
          grant_d      = pick1 ? 2'b10 : 2'b01;
          last_grant_d = pick1;
          mem_rw_d     = pick1 ? bus.req1_rw    : bus.req0_rw;
          mem_addr_d   = pick1 ? bus.req1_addr  : bus.req0_addr;
          mem_wdata_d  = pick1 ? bus.req1_wdata : bus.req0_wdata;
          cnt_d        = CW'(WAIT_CYCLES - 1);
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (mem_rw_q) begin
            rdata_d = bus.mem_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_strobe = (state_q == ACCESS);
  assign bus.mem_rw     = mem_rw_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.grant      = grant_q;
  assign bus.req0_ready = (state_q == DONE) && grant_q[0];
  assign bus.req1_ready = (state_q == DONE) && grant_q[1];
  assign bus.req0_rdata = rdata_q;
  assign bus.req1_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a schedule-level model.
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int W  = 4;

  logic clk = 1'b0;
  logic reset;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   run0   = 0;
  int   run1   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(W)) dut  (.clk(clk), .reset(reset), .bus(bus));
  mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  function automatic logic [7:0] mem_f(input logic [7:0] a);
    return a ^ 8'hB7;
  endfunction

  // Memory model: valid data only in the last cycle of an access, garbage otherwise.
  always @(posedge clk) begin
    run0 <= bus.mem_strobe  ? run0 + 1 : 0;
    run1 <= bus1.mem_strobe ? run1 + 1 : 0;
  end
  assign bus.mem_rdata  = (bus.mem_strobe  && run0 == W - 1) ? mem_f(bus.mem_addr)  : ~mem_f(bus.mem_addr);
  assign bus1.mem_rdata = (bus1.mem_strobe && run1 == 0)     ? mem_f(bus1.mem_addr) : ~mem_f(bus1.mem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.req0_strobe = 0; bus.req0_rw = 0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_strobe = 0; bus.req1_rw = 0; bus.req1_addr = '0; bus.req1_wdata = '0;
    bus1.req0_strobe = 0; bus1.req0_rw = 0; bus1.req0_addr = '0; bus1.req0_wdata = '0;
    bus1.req1_strobe = 0; bus1.req1_rw = 0; bus1.req1_addr = '0; bus1.req1_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [29:0] outs;
    do_reset();
    outs = {bus.grant, bus.mem_strobe, bus.mem_rw, bus.mem_addr, bus.mem_wdata, bus.req0_ready, bus.req1_ready, bus.req0_rdata};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", outs); end
    checks++;
    if (bus.req1_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata1 got %h exp 00", bus.req1_rdata); end
    checks++;
    if ({bus1.grant, bus1.mem_strobe, bus1.req0_ready} !== 4'b0) begin
      errors++; $display("FAIL reset_w1 got %b exp 0000", {bus1.grant, bus1.mem_strobe, bus1.req0_ready});
    end
    tick();
    checks++;
    if ({bus.grant, bus.mem_strobe} !== 3'b000) begin
      errors++; $display("FAIL idle_no_req got %b exp 000", {bus.grant, bus.mem_strobe});
    end
  endtask

  task automatic test_single_read();
    tick();
    bus.req0_strobe = 1; bus.req0_rw = 1; bus.req0_addr = 8'h12;
    for (int c = 1; c <= 7; c++) begin
      tick();
      checks++;
      if (bus.grant !== ((c <= 5) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL single_grant c%0d got %b", c, bus.grant); end
      checks++;
      if (bus.mem_strobe !== (c <= 4)) begin errors++; $display("FAIL single_strobe c%0d got %b", c, bus.mem_strobe); end
      if (c <= 4) begin
        checks++;
        if ({bus.mem_addr, bus.mem_rw} !== {8'h12, 1'b1}) begin
          errors++; $display("FAIL single_addr c%0d got %h/%b exp 12/1", c, bus.mem_addr, bus.mem_rw);
        end
      end
      checks++;
      if (bus.req0_ready !== (c == 5)) begin errors++; $display("FAIL single_ready0 c%0d got %b", c, bus.req0_ready); end
      checks++;
      if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready1 c%0d got %b exp 0", c, bus.req1_ready); end
      if (c == 5) begin
        checks++;
        if (bus.req0_rdata !== 8'hA5) begin errors++; $display("FAIL single_rdata got %h exp a5", bus.req0_rdata); end
        bus.req0_strobe = 0;
      end
    end
  endtask

  task automatic test_tie_after_reset();
    logic [1:0] eg;
    do_reset();
    bus.req0_strobe = 1; bus.req0_rw = 1; bus.req0_addr = 8'h21;
    bus.req1_strobe = 1; bus.req1_rw = 1; bus.req1_addr = 8'h43;
    for (int c = 1; c <= 13; c++) begin
      tick();
      eg = (c <= 5) ? 2'b01 : (c == 6) ? 2'b00 : (c <= 11) ? 2'b10 : 2'b00;
      checks++;
      if (bus.grant !== eg) begin errors++; $display("FAIL tie_grant c%0d got %b exp %b", c, bus.grant, eg); end
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== {c == 5, c == 11}) begin
        errors++; $display("FAIL tie_ready c%0d got %b%b", c, bus.req0_ready, bus.req1_ready);
      end
      if (c >= 7 && c <= 10) begin
        checks++;
        if (bus.mem_addr !== 8'h43) begin errors++; $display("FAIL tie_addr1 c%0d got %h exp 43", c, bus.mem_addr); end
      end
      if (c == 5) begin
        checks++;
        if (bus.req0_rdata !== 8'h96) begin errors++; $display("FAIL tie_rdata0 got %h exp 96", bus.req0_rdata); end
        bus.req0_strobe = 0;
      end
      if (c == 11) begin
        checks++;
        if (bus.req1_rdata !== 8'hF4) begin errors++; $display("FAIL tie_rdata1 got %h exp f4", bus.req1_rdata); end
        bus.req1_strobe = 0;
      end
    end
  endtask

  task automatic test_alternate();
    logic [1:0] got[$];
    logic [1:0] prev_g = 2'b00;
    logic       prev_r0 = 1'b0, prev_r1 = 1'b0;
    tick();
    bus.req0_strobe = 1; bus.req0_rw = 1; bus.req0_addr = 8'h10;
    bus.req1_strobe = 1; bus.req1_rw = 1; bus.req1_addr = 8'h20;
    for (int c = 0; c < 80 && got.size() < 6; c++) begin
      tick();
      if (prev_g == 2'b00 && bus.grant != 2'b00) got.push_back(bus.grant);
      if (bus.req0_ready) begin
        checks++;
        if (prev_r0) begin errors++; $display("FAIL alt_ready0_width got 2+ cycles exp 1"); end
      end
      if (bus.req1_ready) begin
        checks++;
        if (prev_r1) begin errors++; $display("FAIL alt_ready1_width got 2+ cycles exp 1"); end
      end
      if (bus.mem_strobe) begin
        checks++;
        if (bus.mem_addr !== (bus.grant == 2'b10 ? 8'h20 : 8'h10)) begin
          errors++; $display("FAIL alt_addr grant %b got %h", bus.grant, bus.mem_addr);
        end
      end
      prev_g = bus.grant; prev_r0 = bus.req0_ready; prev_r1 = bus.req1_ready;
    end
    bus.req0_strobe = 0; bus.req1_strobe = 0;
    checks++;
    if (got.size() != 6) begin errors++; $display("FAIL alt_count got %0d grants exp 6", got.size()); end
    foreach (got[i]) begin
      checks++;
      if (got[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_order idx%0d got %b", i, got[i]); end
    end
    for (int c = 0; c < 8; c++) tick();
    checks++;
    if (bus.req1_rdata !== 8'h97) begin errors++; $display("FAIL alt_last_rdata got %h exp 97", bus.req1_rdata); end
  endtask

  task automatic test_write();
    tick();
    bus.req1_strobe = 1; bus.req1_rw = 0; bus.req1_addr = 8'h7F; bus.req1_wdata = 8'h3C;
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if (bus.grant !== ((c <= 5) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL wr_grant c%0d got %b", c, bus.grant); end
      checks++;
      if (bus.mem_strobe !== (c <= 4)) begin errors++; $display("FAIL wr_strobe c%0d got %b", c, bus.mem_strobe); end
      checks++;
      if ({bus.mem_rw, bus.mem_addr, bus.mem_wdata} !== {1'b0, 8'h7F, 8'h3C}) begin
        errors++; $display("FAIL wr_bus c%0d got %b/%h/%h exp 0/7f/3c", c, bus.mem_rw, bus.mem_addr, bus.mem_wdata);
      end
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== {1'b0, c == 5}) begin
        errors++; $display("FAIL wr_ready c%0d got %b%b", c, bus.req0_ready, bus.req1_ready);
      end
      if (c == 5) begin
        checks++;
        if ({bus.req0_rdata, bus.req1_rdata} !== {8'h97, 8'h97}) begin
          errors++; $display("FAIL wr_rdata_kept got %h/%h exp 97", bus.req0_rdata, bus.req1_rdata);
        end
        bus.req1_strobe = 0;
      end
    end
  endtask

  task automatic test_reset_mid_access();
    tick();
    bus.req0_strobe = 1; bus.req0_rw = 1; bus.req0_addr = 8'h55;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.mem_strobe, bus.grant, bus.req0_ready, bus.mem_addr} !== 12'h000) begin
      errors++; $display("FAIL rst_mid got strobe %b grant %b ready %b addr %h exp all 0",
                         bus.mem_strobe, bus.grant, bus.req0_ready, bus.mem_addr);
    end
    reset = 1'b0;
    bus.req0_strobe = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.grant} !== 4'b0) begin
        errors++; $display("FAIL rst_no_ready c%0d got %b%b grant %b", c, bus.req0_ready, bus.req1_ready, bus.grant);
      end
    end
    bus.req0_strobe = 1; bus.req0_rw = 1; bus.req0_addr = 8'h66;
    bus.req1_strobe = 1; bus.req1_rw = 1; bus.req1_addr = 8'h77;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) begin
        checks++;
        if (bus.grant !== 2'b01) begin errors++; $display("FAIL rst_tie_grant got %b exp 01", bus.grant); end
        bus.req1_strobe = 0;
      end
      if (c == 5) begin
        checks++;
        if ({bus.req0_ready, bus.req0_rdata} !== {1'b1, 8'hD1}) begin
          errors++; $display("FAIL rst_tie_done got %b/%h exp 1/d1", bus.req0_ready, bus.req0_rdata);
        end
        bus.req0_strobe = 0;
      end
    end
    tick();
  endtask

  task automatic test_drop_mid_access();
    tick();
    bus.req0_strobe = 1; bus.req0_rw = 1; bus.req0_addr = 8'h33;
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if (bus.mem_strobe !== (c <= 4)) begin errors++; $display("FAIL drop_strobe c%0d got %b", c, bus.mem_strobe); end
      checks++;
      if (bus.req0_ready !== (c == 5)) begin errors++; $display("FAIL drop_ready c%0d got %b", c, bus.req0_ready); end
      if (c == 2) bus.req0_strobe = 0;
      if (c == 5) begin
        checks++;
        if (bus.req0_rdata !== 8'h84) begin errors++; $display("FAIL drop_rdata got %h exp 84", bus.req0_rdata); end
      end
    end
  endtask

  task automatic test_wait_one();
    tick();
    bus1.req0_strobe = 1; bus1.req0_rw = 1; bus1.req0_addr = 8'h44;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (bus1.mem_strobe !== (c == 1)) begin errors++; $display("FAIL w1_strobe c%0d got %b", c, bus1.mem_strobe); end
      checks++;
      if (bus1.grant !== ((c <= 2) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL w1_grant c%0d got %b", c, bus1.grant); end
      checks++;
      if (bus1.req0_ready !== (c == 2)) begin errors++; $display("FAIL w1_ready c%0d got %b", c, bus1.req0_ready); end
      if (c == 2) begin
        checks++;
        if (bus1.req0_rdata !== 8'hF3) begin errors++; $display("FAIL w1_rdata got %h exp f3", bus1.req0_rdata); end
        bus1.req0_strobe = 0;
      end
    end
  endtask

  // Reference: a transaction decided in cycle d owns the port for d+1..d+W+1, ready at d+W+1.
  task automatic test_random();
    logic       pend[2];
    logic       strb[2];
    logic       rw[2];
    logic [7:0] addr[2];
    logic [7:0] wd[2];
    logic       active = 0, m_last = 1, own = 0, m_rw = 0;
    logic [7:0] m_addr = 0, m_wd = 0, m_rdata = 0;
    int         d = -100, free_at;
    logic       in_acc, at_done;
    logic [1:0] eg;
    do_reset();
    free_at = cyc;
    for (int r = 0; r < 2; r++) begin pend[r] = 0; strb[r] = 0; rw[r] = 0; addr[r] = 0; wd[r] = 0; end
    for (int n = 0; n < 600; n++) begin
      tick();
      in_acc  = active && cyc >= d + 1 && cyc <= d + W;
      at_done = active && cyc == d + W + 1;
      eg = (in_acc || at_done) ? (own ? 2'b10 : 2'b01) : 2'b00;
      if (at_done && m_rw) m_rdata = mem_f(m_addr);
      checks++;
      if (bus.grant !== eg) begin errors++; $display("FAIL rnd_grant cyc%0d got %b exp %b", cyc, bus.grant, eg); end
      checks++;
      if (bus.mem_strobe !== in_acc) begin errors++; $display("FAIL rnd_strobe cyc%0d got %b exp %b", cyc, bus.mem_strobe, in_acc); end
      checks++;
      if ({bus.mem_rw, bus.mem_addr, bus.mem_wdata} !== {m_rw, m_addr, m_wd}) begin
        errors++; $display("FAIL rnd_membus cyc%0d got %b/%h/%h exp %b/%h/%h", cyc,
                           bus.mem_rw, bus.mem_addr, bus.mem_wdata, m_rw, m_addr, m_wd);
      end
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== {at_done && !own, at_done && own}) begin
        errors++; $display("FAIL rnd_ready cyc%0d got %b%b", cyc, bus.req0_ready, bus.req1_ready);
      end
      checks++;
      if ({bus.req0_rdata, bus.req1_rdata} !== {m_rdata, m_rdata}) begin
        errors++; $display("FAIL rnd_rdata cyc%0d got %h/%h exp %h", cyc, bus.req0_rdata, bus.req1_rdata, m_rdata);
      end
      if (at_done) begin
        active = 0; pend[own] = 0; strb[own] = 0;
      end
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && !(at_done && own == r) && $urandom_range(3) == 0) begin
          pend[r] = 1; strb[r] = 1;
          rw[r] = 1'($urandom_range(1)); addr[r] = 8'($urandom); wd[r] = 8'($urandom);
        end else if (in_acc && own == r && $urandom_range(7) == 0) begin
          strb[r] = 0;
        end
      end
      if (!active && cyc >= free_at && (pend[0] || pend[1])) begin
        own     = (pend[0] && pend[1]) ? !m_last : pend[1];
        m_last  = own;
        m_rw    = rw[own]; m_addr = addr[own]; m_wd = wd[own];
        d       = cyc;
        free_at = cyc + W + 2;
        active  = 1;
      end
      bus.req0_strobe = strb[0]; bus.req0_rw = rw[0]; bus.req0_addr = addr[0]; bus.req0_wdata = wd[0];
      bus.req1_strobe = strb[1]; bus.req1_rw = rw[1]; bus.req1_addr = addr[1]; bus.req1_wdata = wd[1];
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_tie_after_reset();
    test_alternate();
    test_write();
    test_reset_mid_access();
    test_drop_mid_access();
    test_wait_one();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
